// File: rtl/if_id_fetch_queue_pkg.sv
// rtl/if_id_fetch_queue_pkg.sv - shared fetch-path constants and the fetch entry record
package if_id_fetch_queue_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// rtl/if_id_fetch_queue_if.sv - fetch-side and decode-side signals of the IF/ID queue
interface if_id_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_fetch;
    logic [DATA_W-1:0] imem_rdata;
    logic              flush;
    logic              id_ready;
    logic              pc_stall;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [ADDR_W-1:0] id_pc_plus4;
    logic [DATA_W-1:0] id_instr;
    logic [CNT_W-1:0]  occupancy;

    modport master (
        output pc_fetch, imem_rdata, flush, id_ready,
        input  pc_stall, id_valid, id_pc, id_pc_plus4, id_instr, occupancy
    );

    modport slave (
        input  pc_fetch, imem_rdata, flush, id_ready,
        output pc_stall, id_valid, id_pc, id_pc_plus4, id_instr, occupancy
    );

endinterface

// File: rtl/if_id_fetch_queue_ram.sv
// rtl/if_id_fetch_queue_ram.sv - entry storage: one write port, one asynchronous read port
module if_id_fetch_queue_ram #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents need no reset: the control logic never exposes an unwritten slot.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - IF/ID fetch queue: buffers {pc, instr}, stalls PC when full, flushes on redirect
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input logic                clk_i,
    input logic                reset_i,
    if_id_fetch_queue_if.slave bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop, not_empty;
    logic [ENTRY_W-1:0] rd_entry;
    logic [ADDR_W-1:0]  head_pc;

    assign not_empty = (count_q != '0);

    // Flush and reset both suppress the handshake in the same cycle.
    assign bus.id_valid = reset_i & not_empty & ~bus.flush;
    assign pop          = bus.id_valid & bus.id_ready;
    assign push         = reset_i & ~bus.flush & ((count_q < CNT_W'(DEPTH)) | pop);
    assign bus.pc_stall = reset_i & ~bus.flush & ~push;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (bus.flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    if_id_fetch_queue_ram #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (push),
        .waddr_i(wr_ptr_q),
        .wdata_i({bus.pc_fetch, bus.imem_rdata}),
        .raddr_i(rd_ptr_q),
        .rdata_o(rd_entry)
    );

    assign head_pc         = not_empty ? rd_entry[ENTRY_W-1:DATA_W] : '0;
    assign bus.id_pc       = head_pc;
    assign bus.id_pc_plus4 = head_pc + ADDR_W'(PC_STEP);
    assign bus.id_instr    = not_empty ? rd_entry[DATA_W-1:0] : DATA_W'(NOP_INSTR);
    assign bus.occupancy   = count_q;

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb/tb_if_id_fetch_queue.sv - directed bench for if_id_fetch_queue with a queue-based reference model
module tb_if_id_fetch_queue;
    import if_id_fetch_queue_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_fetch_queue_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

    if_id_fetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    int           n_vec  = 0;
    int           n_fail = 0;
    fetch_entry_t mq[$];
    bit           model_ok = 1'b0;
    logic [AW-1:0] dut_log[$];
    int           log_mark;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_pop();
        return reset === 1'b1 && mq.size() != 0 && bus.flush === 1'b0 && bus.id_ready === 1'b1;
    endfunction

    function automatic bit m_push();
        return reset === 1'b1 && bus.flush === 1'b0 && (mq.size() < DEPTH || m_pop());
    endfunction

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            mq.delete();
            model_ok <= 1'b1;
        end else if (bus.flush === 1'b1) begin
            mq.delete();
        end else begin
            case ({m_pop(), m_push()})
                2'b11: begin
                    void'(mq.pop_front());
                    mq.push_back('{pc: bus.pc_fetch, instr: bus.imem_rdata});
                end
                2'b10: void'(mq.pop_front());
                2'b01: mq.push_back('{pc: bus.pc_fetch, instr: bus.imem_rdata});
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("id_valid", 64'(bus.id_valid),
                64'(reset === 1'b1 && mq.size() != 0 && bus.flush === 1'b0));
            chk("pc_stall", 64'(bus.pc_stall),
                64'(reset === 1'b1 && bus.flush === 1'b0 && !m_push()));
            chk("occupancy", 64'(bus.occupancy), 64'(mq.size()));
            if (mq.size() != 0) begin
                chk("id_pc", 64'(bus.id_pc), 64'(mq[0].pc));
                chk("id_pc_plus4", 64'(bus.id_pc_plus4), 64'((mq[0].pc + 64'd4) % 64'h1_0000_0000));
                chk("id_instr", 64'(bus.id_instr), 64'(mq[0].instr));
            end else begin
                chk("id_pc_empty", 64'(bus.id_pc), 64'd0);
                chk("id_pc_plus4_empty", 64'(bus.id_pc_plus4), 64'd4);
                chk("id_instr_empty", 64'(bus.id_instr), 64'(NOP_INSTR));
            end
            if (bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
                dut_log.push_back(bus.id_pc);
            end
        end
    end

    task automatic drive(input logic rst, input logic [AW-1:0] pc, input logic [DW-1:0] ins,
                         input logic fl, input logic rdy);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.pc_fetch   = pc;
        bus.imem_rdata = ins;
        bus.flush      = fl;
        bus.id_ready   = rdy;
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b0;
        bus.pc_fetch   = 32'h40;
        bus.imem_rdata = 32'h0;
        bus.flush      = 1'b0;
        bus.id_ready   = 1'b0;

        // reset for two cycles
        drive(0, 32'h40, 32'h0, 0, 0);
        drive(0, 32'h40, 32'h0, 0, 0);
        chk("t1_occ", 64'(bus.occupancy), 64'd0);
        chk("t1_valid", 64'(bus.id_valid), 64'd0);
        chk("t1_stall", 64'(bus.pc_stall), 64'd0);
        chk("t1_instr", 64'(bus.id_instr), 64'h0);
        chk("t1_pc", 64'(bus.id_pc), 64'h0);

        // streaming with decode always ready
        drive(1, 32'h0, 32'h2008_0001, 0, 1);
        chk("t2_valid0", 64'(bus.id_valid), 64'd0);
        chk("t2_stall0", 64'(bus.pc_stall), 64'd0);
        drive(1, 32'h4, 32'h2009_0002, 0, 1);
        chk("t2_pc0", 64'(bus.id_pc), 64'h0);
        chk("t2_p40", 64'(bus.id_pc_plus4), 64'h4);
        chk("t2_ins0", 64'(bus.id_instr), 64'h2008_0001);
        chk("t2_stall1", 64'(bus.pc_stall), 64'd0);
        drive(1, 32'h8, 32'h012A_4020, 0, 1);
        chk("t2_pc1", 64'(bus.id_pc), 64'h4);
        chk("t2_p41", 64'(bus.id_pc_plus4), 64'h8);
        chk("t2_ins1", 64'(bus.id_instr), 64'h2009_0002);
        drive(1, 32'h10, 32'hDEAD_0010, 0, 1);
        chk("t2_pc2", 64'(bus.id_pc), 64'h8);
        chk("t2_p42", 64'(bus.id_pc_plus4), 64'hC);
        chk("t2_ins2", 64'(bus.id_instr), 64'h012A_4020);
        chk("t2_stall2", 64'(bus.pc_stall), 64'd0);
        drive(1, 32'h14, 32'hDEAD_0014, 1, 1);
        chk("t2_flush_valid", 64'(bus.id_valid), 64'd0);
        chk("t2_log_n", 64'(dut_log.size()), 64'd3);
        chk("t2_log0", 64'(dut_log[0]), 64'h0);
        chk("t2_log1", 64'(dut_log[1]), 64'h4);
        chk("t2_log2", 64'(dut_log[2]), 64'h8);

        // fill with decode stalled, then release
        drive(1, 32'h0, 32'h2008_0001, 0, 0);
        chk("t3_occ0", 64'(bus.occupancy), 64'd0);
        drive(1, 32'h4, 32'h2009_0002, 0, 0);
        chk("t3_occ1", 64'(bus.occupancy), 64'd1);
        drive(1, 32'h8, 32'h012A_4020, 0, 0);
        chk("t3_occ2", 64'(bus.occupancy), 64'd2);
        chk("t3_stall_full", 64'(bus.pc_stall), 64'd1);
        drive(1, 32'h8, 32'h012A_4020, 0, 0);
        chk("t3_stall_hold", 64'(bus.pc_stall), 64'd1);
        drive(1, 32'h8, 32'h012A_4020, 0, 1);
        chk("t3_stall_rel", 64'(bus.pc_stall), 64'd0);
        chk("t3_pc_rel", 64'(bus.id_pc), 64'h0);
        drive(1, 32'hC, 32'hDEAD_000C, 0, 1);
        chk("t3_pc4", 64'(bus.id_pc), 64'h4);
        drive(1, 32'h10, 32'hDEAD_0010, 0, 1);
        chk("t3_pc8", 64'(bus.id_pc), 64'h8);

        // flush with two entries held and decode ready
        drive(1, 32'h14, 32'hDEAD_0014, 1, 1);
        chk("t4_occ_pre", 64'(bus.occupancy), 64'd2);
        chk("t4_valid", 64'(bus.id_valid), 64'd0);
        chk("t4_stall", 64'(bus.pc_stall), 64'd0);
        chk("t3_log_n", 64'(dut_log.size()), 64'd6);
        chk("t3_log3", 64'(dut_log[3]), 64'h0);
        chk("t3_log4", 64'(dut_log[4]), 64'h4);
        chk("t3_log5", 64'(dut_log[5]), 64'h8);
        drive(1, 32'h100, 32'h1111_1111, 0, 0);
        chk("t4_occ_post", 64'(bus.occupancy), 64'd0);
        drive(1, 32'h104, 32'h2222_2222, 0, 1);
        chk("t4_redirect_pc", 64'(bus.id_pc), 64'h100);
        chk("t4_redirect_ins", 64'(bus.id_instr), 64'h1111_1111);

        // pc+4 wraps at the top of the address space
        drive(1, 32'hFFFF_FFFC, 32'h3333_3333, 0, 1);
        chk("t5_pc104", 64'(bus.id_pc), 64'h104);
        drive(1, 32'h200, 32'h4444_4444, 0, 0);
        chk("t5_pc_top", 64'(bus.id_pc), 64'hFFFF_FFFC);
        chk("t5_p4_wrap", 64'(bus.id_pc_plus4), 64'h0);
        drive(1, 32'h204, 32'h5555_5555, 0, 0);
        chk("t6_full", 64'(bus.pc_stall), 64'd1);

        // reset while full and decode ready
        log_mark = dut_log.size();
        drive(0, 32'h204, 32'h5555_5555, 0, 1);
        chk("t6_valid", 64'(bus.id_valid), 64'd0);
        chk("t6_stall", 64'(bus.pc_stall), 64'd0);
        drive(1, 32'h300, 32'h6666_6666, 0, 0);
        chk("t6_occ", 64'(bus.occupancy), 64'd0);
        chk("t6_valid_after", 64'(bus.id_valid), 64'd0);
        chk("t6_no_pop", 64'(dut_log.size()), 64'(log_mark));

        // mixed traffic across pointer wraps, one flush and one reset
        for (int i = 0; i < 24; i++) begin
            drive((i == 17) ? 1'b0 : 1'b1, 32'h304 + 32'(4 * i), 32'hA000_0000 + 32'(i),
                  (i == 11) ? 1'b1 : 1'b0, (i % 3 != 2) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
